// File: rtl/mt_bus_pkg.sv
// Shared definitions for the Matrak memory bus: arbitration mode codes
// and the helper that sizes port-index signals.
package mt_bus_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // A single-port system still needs a 1-bit index so that no vector is zero-width.
  function automatic int idx_width(input int num_ports);
    return (num_ports <= 1) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin search starting at ptr, or
// fixed priority with port 0 highest. Also returns the index of the winner.
module rr_arbiter
  import mt_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = ARB_RR,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx
);

  logic found;
  int   k;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = (ARB_MODE == ARB_FIXED) ? i : (int'(ptr) + i) % NUM_PORTS;
      if (!found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one single-port synchronous memory: request/grant
// handshake, byte-enabled writes and a one-cycle read-valid return.
module mem_arbiter
  import mt_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = ARB_RR
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]       addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]       wdata_i,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0]   be_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic                              mem_en_o,
  output logic                              mem_we_o,
  output logic [DATA_W/8-1:0]               mem_be_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     rtag_idx_q;
  logic                 rtag_valid_q;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic                 granted;
  logic                 sel_we;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req     (req_i),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are suppressed while reset is held, so nothing reaches the memory.
  assign gnt_o   = rst_i ? '0 : arb_gnt;
  assign granted = |gnt_o;
  assign sel_we  = we_i[gnt_idx];

  always_comb begin
    mem_en_o    = granted;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (granted) begin
      mem_we_o    = sel_we;
      mem_addr_o  = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
      mem_wdata_o = wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
      if (sel_we) mem_be_o = be_i[int'(gnt_idx)*BE_W +: BE_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ARB_MODE == ARB_FIXED) begin
      ptr_d = '0;
    end else if (granted) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      rtag_valid_q <= 1'b0;
      rtag_idx_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rtag_valid_q <= granted & ~sel_we;
      rtag_idx_q   <= gnt_idx;
    end
  end

  // A read accepted just before reset is dropped rather than returned.
  always_comb begin
    rvalid_o = '0;
    if (rtag_valid_q && !rst_i) rvalid_o[rtag_idx_q] = 1'b1;
  end

  assign rdata_o = (|rvalid_o) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-port round-robin instance backed by a
// small memory model, and a 4-port fixed-priority instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance, 2 ports
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
  logic [63:0] addr_a, wdata_a;
  logic [7:0]  be_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        mem_en_a, mem_we_a;
  logic [3:0]  mem_be_a;

  // Fixed-priority instance, 4 ports
  logic [3:0]   req_b, we_b, gnt_b, rvalid_b;
  logic [127:0] addr_b, wdata_b;
  logic [15:0]  be_b;
  logic [31:0]  rdata_b, mem_addr_b, mem_wdata_b;
  logic [31:0]  mem_rdata_b = 32'h0;
  logic         mem_en_b, mem_we_b;
  logic [3:0]   mem_be_b;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .be_i(be_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .mem_en_o(mem_en_a), .mem_we_o(mem_we_a),
    .mem_be_o(mem_be_a), .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
    .mem_rdata_i(mem_rdata_a)
  );

  mem_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .be_i(be_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_be_o(mem_be_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
    .mem_rdata_i(mem_rdata_b)
  );

  // Single-port synchronous memory model, word-indexed
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_a[b]) mem[mem_addr_a[5:2]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
      end else begin
        mem_rdata_a <= mem[mem_addr_a[5:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[1] = 32'hAABBCCDD;
    mem_rdata_a = 32'h0;

    rst = 1'b1;
    req_a = 2'b11; we_a = 2'b00; addr_a = '0; wdata_a = '0; be_a = '0;
    req_b = 4'b1111; we_b = '0; addr_b = '0; wdata_b = '0; be_b = '0;

    // Reset held three cycles with requests pending
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", gnt_a, 2'b00);
      check("rst_mem_en", mem_en_a, 1'b0);
      check("rst_rvalid", rvalid_a, 2'b00);
      check("rst_gnt_b", gnt_b, 4'b0000);
    end

    // Single read from port 1
    next_cycle();
    rst = 1'b0;
    req_a = 2'b10; addr_a[63:32] = 32'h10;
    req_b = 4'b0000;
    @(negedge clk);
    check("rd_gnt", gnt_a, 2'b10);
    check("rd_mem_en", mem_en_a, 1'b1);
    check("rd_mem_we", mem_we_a, 1'b0);
    check("rd_mem_addr", mem_addr_a, 32'h10);
    check("rd_mem_be", mem_be_a, 4'hF);
    next_cycle();
    req_a = 2'b00;
    @(negedge clk);
    check("rd_rvalid", rvalid_a, 2'b10);
    check("rd_rdata", rdata_a, 32'hDEADBEEF);
    check("rd_gnt_idle", gnt_a, 2'b00);

    // Round-robin with both ports requesting reads continuously
    next_cycle();
    req_a = 2'b11; addr_a[31:0] = 32'h10; addr_a[63:32] = 32'h10;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rr_gnt_%0d", c), gnt_a, (c % 2 == 1) ? 2'b10 : 2'b01);
      if (c > 0) check($sformatf("rr_rvalid_%0d", c), rvalid_a, (c % 2 == 1) ? 2'b01 : 2'b10);
      next_cycle();
    end
    req_a = 2'b00;
    @(negedge clk);
    check("rr_rvalid_last", rvalid_a, 2'b10);

    // Byte-enabled write from port 0, then read back
    next_cycle();
    req_a = 2'b01; we_a = 2'b01;
    addr_a[31:0] = 32'h4; wdata_a[31:0] = 32'h11223344; be_a[3:0] = 4'b0011;
    @(negedge clk);
    check("wr_gnt", gnt_a, 2'b01);
    check("wr_mem_we", mem_we_a, 1'b1);
    check("wr_mem_be", mem_be_a, 4'b0011);
    check("wr_mem_wdata", mem_wdata_a, 32'h11223344);
    check("wr_mem_addr", mem_addr_a, 32'h4);
    next_cycle();
    req_a = 2'b00; we_a = 2'b00;
    @(negedge clk);
    check("wr_no_rvalid", rvalid_a, 2'b00);
    next_cycle();
    req_a = 2'b01; be_a[3:0] = 4'b0000;
    @(negedge clk);
    check("rb_gnt", gnt_a, 2'b01);
    check("rb_mem_be_forced", mem_be_a, 4'hF);
    next_cycle();
    req_a = 2'b00;
    @(negedge clk);
    check("rb_rvalid", rvalid_a, 2'b01);
    check("rb_rdata", rdata_a, 32'hAABB3344);

    // Reset in the cycle after a read grant; pointer would otherwise be 1
    next_cycle();
    req_a = 2'b01; addr_a[31:0] = 32'h10;
    @(negedge clk);
    check("rm_gnt", gnt_a, 2'b01);
    next_cycle();
    rst = 1'b1; req_a = 2'b00;
    @(negedge clk);
    check("rm_rvalid", rvalid_a, 2'b00);
    check("rm_rdata", rdata_a, 32'h0);
    next_cycle();
    rst = 1'b0; req_a = 2'b11;
    @(negedge clk);
    check("rm_ptr_zero", gnt_a, 2'b01);
    check("rm_rvalid_after", rvalid_a, 2'b00);
    next_cycle();
    req_a = 2'b00;

    // Fixed priority, 4 ports
    req_b = 4'b1110;
    repeat (3) begin
      @(negedge clk);
      check("fx_gnt_1110", gnt_b, 4'b0010);
      next_cycle();
    end
    @(negedge clk);
    check("fx_rvalid", rvalid_b, 4'b0010);
    next_cycle();
    req_b = 4'b1000;
    @(negedge clk);
    check("fx_gnt_1000", gnt_b, 4'b1000);
    next_cycle();
    req_b = 4'b1100;
    @(negedge clk);
    check("fx_gnt_1100", gnt_b, 4'b0100);
    next_cycle();
    req_b = 4'b0000;
    @(negedge clk);
    check("fx_gnt_none", gnt_b, 4'b0000);
    check("fx_mem_en_none", mem_en_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
